// File: rtl/mem_unit_ws.sv
// mem_unit_ws: unified word-organised instruction/data memory with two
// independent request/response ports and configurable wait states.
//
// Handshake (both ports): a request is accepted on a rising edge where
// ready=1 and req=1. The response is a one-cycle valid pulse carrying
// rdata/exc/cause/mtval. There is no response backpressure. A req seen while
// ready=0 is ignored, so the requester holds req until ready.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset (0 = reset)
//   i_req/i_addr      fetch request and byte address
//   i_ready/i_valid   fetch port idle / response pulse
//   i_rdata           fetched word (0 on a trap)
//   i_exc/i_cause     fetch trap: 0 misaligned, 1 access fault
//   i_mtval           faulting fetch address (0 when no trap)
//   d_req/d_we        data request; 1 = store, 0 = load
//   d_size            00 byte, 01 half, 10 word, 11 treated as word
//   d_unsigned        zero-extend sub-word loads
//   d_addr/d_wdata    byte address; right-justified store data
//   d_ready/d_valid   data port idle / response pulse
//   d_rdata           extended load result (0 for stores and traps)
//   d_exc/d_cause     data trap: 4/5 load misaligned/fault, 6/7 store
//   d_mtval           faulting data address (0 when no trap)
//   o_dbg_state       {data FSM state, fetch FSM state}
//
// INIT_FILE names the hex image that the memory-preload flow places into the
// array; the array itself is never cleared by reset.
module mem_unit_ws #(
  parameter int unsigned DEPTH_WORDS = 65536,
  parameter int unsigned I_LATENCY   = 0,
  parameter int unsigned D_LATENCY   = 1,
  parameter              INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic        i_valid,
  output logic [31:0] i_rdata,
  output logic        i_exc,
  output logic [4:0]  i_cause,
  output logic [31:0] i_mtval,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic        d_unsigned,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        d_exc,
  output logic [4:0]  d_cause,
  output logic [31:0] d_mtval,
  output logic [3:0]  o_dbg_state
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  logic [31:0] r_mem [DEPTH_WORDS];

  // ---------------------------------------------------------------- fetch port
  state_t      r_i_state, w_i_state_nxt;
  logic [3:0]  r_i_cnt;
  logic [31:0] r_i_addr;
  logic        r_i_exc;
  logic [4:0]  r_i_cause;
  logic [31:0] r_i_rdata;
  logic        w_i_acc, w_i_mis, w_i_oor, w_i_trap, w_i_go;
  logic [4:0]  w_i_cause_nxt;
  logic [AW-1:0] w_i_widx;

  assign w_i_acc       = (r_i_state == S_IDLE) && i_req;
  assign w_i_mis       = (i_addr[1:0] != 2'b00);
  assign w_i_oor       = ({2'b00, i_addr[31:2]} >= DEPTH_WORDS);
  assign w_i_trap      = w_i_mis || w_i_oor;
  assign w_i_cause_nxt = w_i_mis ? 5'd0 : 5'd1;
  // Array read happens on the edge entering RESP: straight from IDLE when
  // there are no wait states, otherwise when the wait counter reaches zero.
  assign w_i_go   = rst && ((w_i_acc && !w_i_trap && (I_LATENCY == 0)) ||
                            ((r_i_state == S_WAIT) && (r_i_cnt == 4'd0)));
  assign w_i_widx = (r_i_state == S_IDLE) ? i_addr[AW+1:2] : r_i_addr[AW+1:2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_i_state <= S_IDLE;
    else      r_i_state <= w_i_state_nxt;
  end

  always_comb begin
    w_i_state_nxt = r_i_state;
    case (r_i_state)
      S_IDLE:  if (i_req) w_i_state_nxt = (w_i_trap || (I_LATENCY == 0)) ? S_RESP : S_WAIT;
      S_WAIT:  if (r_i_cnt == 4'd0) w_i_state_nxt = S_RESP;
      default: w_i_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    i_ready = 1'b0;
    i_valid = 1'b0;
    i_rdata = '0;
    i_exc   = 1'b0;
    i_cause = '0;
    i_mtval = '0;
    case (r_i_state)
      S_IDLE: i_ready = 1'b1;
      S_RESP: begin
        i_valid = 1'b1;
        i_exc   = r_i_exc;
        if (r_i_exc) begin
          i_cause = r_i_cause;
          i_mtval = r_i_addr;
        end else begin
          i_rdata = r_i_rdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_i_cnt   <= '0;
      r_i_addr  <= '0;
      r_i_exc   <= 1'b0;
      r_i_cause <= '0;
    end else if (w_i_acc) begin
      r_i_cnt   <= 4'(I_LATENCY - 1);
      r_i_addr  <= i_addr;
      r_i_exc   <= w_i_trap;
      r_i_cause <= w_i_cause_nxt;
    end else if ((r_i_state == S_WAIT) && (r_i_cnt != 4'd0)) begin
      r_i_cnt <= r_i_cnt - 4'd1;
    end
  end

  // ----------------------------------------------------------------- data port
  state_t      r_d_state, w_d_state_nxt;
  logic [3:0]  r_d_cnt;
  logic [31:0] r_d_addr;
  logic        r_d_we, r_d_uns, r_d_exc;
  logic [1:0]  r_d_size;
  logic [31:0] r_d_wdata;
  logic [4:0]  r_d_cause;
  logic [31:0] r_d_rdata;
  logic        w_d_acc, w_d_mis, w_d_oor, w_d_trap, w_d_go;
  logic [4:0]  w_d_cause_nxt;
  logic [AW+1:0] w_d_cur_addr;
  logic        w_d_cur_we, w_d_cur_uns;
  logic [1:0]  w_d_cur_size;
  logic [31:0] w_d_cur_wdata;
  logic [AW-1:0] w_d_widx;
  logic [3:0]  w_d_mask;
  logic [31:0] w_d_wlane, w_d_word, w_d_load;
  logic [7:0]  w_d_byte;
  logic [15:0] w_d_half;

  assign w_d_acc = (r_d_state == S_IDLE) && d_req;
  assign w_d_mis = ((d_size == 2'b01) && d_addr[0]) ||
                   (d_size[1] && (d_addr[1:0] != 2'b00));
  assign w_d_oor = ({2'b00, d_addr[31:2]} >= DEPTH_WORDS);
  assign w_d_trap = w_d_mis || w_d_oor;
  assign w_d_cause_nxt = w_d_mis ? (d_we ? 5'd6 : 5'd4) : (d_we ? 5'd7 : 5'd5);
  assign w_d_go = rst && ((w_d_acc && !w_d_trap && (D_LATENCY == 0)) ||
                          ((r_d_state == S_WAIT) && (r_d_cnt == 4'd0)));

  // With zero wait states the access uses the request inputs directly;
  // otherwise it uses the fields latched at acceptance.
  assign w_d_cur_addr  = (r_d_state == S_IDLE) ? d_addr[AW+1:0] : r_d_addr[AW+1:0];
  assign w_d_cur_we    = (r_d_state == S_IDLE) ? d_we       : r_d_we;
  assign w_d_cur_uns   = (r_d_state == S_IDLE) ? d_unsigned : r_d_uns;
  assign w_d_cur_size  = (r_d_state == S_IDLE) ? d_size     : r_d_size;
  assign w_d_cur_wdata = (r_d_state == S_IDLE) ? d_wdata    : r_d_wdata;
  assign w_d_widx      = w_d_cur_addr[AW+1:2];

  // Store lanes: sub-word data is replicated across the word and the mask
  // picks the lanes actually written.
  always_comb begin
    w_d_mask  = 4'b1111;
    w_d_wlane = w_d_cur_wdata;
    case (w_d_cur_size)
      2'b00: begin
        w_d_mask  = 4'b0001 << w_d_cur_addr[1:0];
        w_d_wlane = {4{w_d_cur_wdata[7:0]}};
      end
      2'b01: begin
        w_d_mask  = w_d_cur_addr[1] ? 4'b1100 : 4'b0011;
        w_d_wlane = {2{w_d_cur_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane extraction and extension.
  always_comb begin
    w_d_word = r_mem[w_d_widx];
    case (w_d_cur_addr[1:0])
      2'd0:    w_d_byte = w_d_word[7:0];
      2'd1:    w_d_byte = w_d_word[15:8];
      2'd2:    w_d_byte = w_d_word[23:16];
      default: w_d_byte = w_d_word[31:24];
    endcase
    w_d_half = w_d_cur_addr[1] ? w_d_word[31:16] : w_d_word[15:0];
    case (w_d_cur_size)
      2'b00:   w_d_load = w_d_cur_uns ? {24'd0, w_d_byte} : {{24{w_d_byte[7]}}, w_d_byte};
      2'b01:   w_d_load = w_d_cur_uns ? {16'd0, w_d_half} : {{16{w_d_half[15]}}, w_d_half};
      default: w_d_load = w_d_word;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_d_state <= S_IDLE;
    else      r_d_state <= w_d_state_nxt;
  end

  always_comb begin
    w_d_state_nxt = r_d_state;
    case (r_d_state)
      S_IDLE:  if (d_req) w_d_state_nxt = (w_d_trap || (D_LATENCY == 0)) ? S_RESP : S_WAIT;
      S_WAIT:  if (r_d_cnt == 4'd0) w_d_state_nxt = S_RESP;
      default: w_d_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    d_ready = 1'b0;
    d_valid = 1'b0;
    d_rdata = '0;
    d_exc   = 1'b0;
    d_cause = '0;
    d_mtval = '0;
    case (r_d_state)
      S_IDLE: d_ready = 1'b1;
      S_RESP: begin
        d_valid = 1'b1;
        d_exc   = r_d_exc;
        if (r_d_exc) begin
          d_cause = r_d_cause;
          d_mtval = r_d_addr;
        end else begin
          d_rdata = r_d_rdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_d_cnt   <= '0;
      r_d_addr  <= '0;
      r_d_we    <= 1'b0;
      r_d_uns   <= 1'b0;
      r_d_size  <= '0;
      r_d_wdata <= '0;
      r_d_exc   <= 1'b0;
      r_d_cause <= '0;
    end else if (w_d_acc) begin
      r_d_cnt   <= 4'(D_LATENCY - 1);
      r_d_addr  <= d_addr;
      r_d_we    <= d_we;
      r_d_uns   <= d_unsigned;
      r_d_size  <= d_size;
      r_d_wdata <= d_wdata;
      r_d_exc   <= w_d_trap;
      r_d_cause <= w_d_cause_nxt;
    end else if ((r_d_state == S_WAIT) && (r_d_cnt != 4'd0)) begin
      r_d_cnt <= r_d_cnt - 4'd1;
    end
  end

  // --------------------------------------------------------------------- array
  // Non-blocking semantics give read-before-write when a fetch and a store
  // hit the same word on the same edge. Response data registers need no
  // reset: the outputs are gated by the RESP state.
  always_ff @(posedge clk) begin
    if (w_d_go) begin
      if (w_d_cur_we) begin
        for (int b = 0; b < 4; b++) begin
          if (w_d_mask[b]) r_mem[w_d_widx][8*b +: 8] <= w_d_wlane[8*b +: 8];
        end
        r_d_rdata <= '0;
      end else begin
        r_d_rdata <= w_d_load;
      end
    end
    if (w_i_go) r_i_rdata <= r_mem[w_i_widx];
  end

  assign o_dbg_state = {r_d_state, r_i_state};

endmodule

// File: tb/tb_mem_unit_ws.sv
module tb_mem_unit_ws;
  localparam int DEPTH = 8192;
  localparam int I_LAT = 3;
  localparam int D_LAT = 1;
  localparam int EW    = 102;  // {cycle, rdata, exc, cause, mtval}

  // ------------------------------------------------------ clock / reset block
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ready, i_valid, i_exc;
  logic [31:0] i_rdata, i_mtval;
  logic [4:0]  i_cause;
  logic        d_req = 1'b0, d_we = 1'b0, d_unsigned = 1'b0;
  logic [1:0]  d_size = '0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic        d_ready, d_valid, d_exc;
  logic [31:0] d_rdata, d_mtval;
  logic [4:0]  d_cause;
  logic [3:0]  dbg_state;

  mem_unit_ws #(.DEPTH_WORDS(DEPTH), .I_LATENCY(I_LAT), .D_LATENCY(D_LAT), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_valid(i_valid),
    .i_rdata(i_rdata), .i_exc(i_exc), .i_cause(i_cause), .i_mtval(i_mtval),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready), .d_valid(d_valid),
    .d_rdata(d_rdata), .d_exc(d_exc), .d_cause(d_cause), .d_mtval(d_mtval),
    .o_dbg_state(dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [EW-1:0] i_q[$];
  logic [EW-1:0] d_q[$];
  logic [7:0] mb [int unsigned];  // byte-addressed reference memory

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic note_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired or unexpected event (cycle %0d)", name, cyc);
  endtask

  // ------------------------------------------------------- reference model
  function automatic logic [EW-1:0] d_model(input bit we, input logic [1:0] size, input bit uns,
                                            input logic [31:0] addr, input logic [31:0] wdata,
                                            input int icyc);
    int nb;
    bit mis, oor, exc;
    logic [4:0] cause;
    logic [31:0] rd;
    longint v;
    nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    mis = (addr % nb) != 0;
    oor = (addr / 4) >= DEPTH;
    exc = mis || oor;
    cause = mis ? (we ? 5'd6 : 5'd4) : oor ? (we ? 5'd7 : 5'd5) : 5'd0;
    rd = '0;
    if (!exc) begin
      if (we) begin
        for (int k = 0; k < nb; k++) mb[addr + k] = 8'((wdata >> (8 * k)) & 32'hFF);
      end else begin
        v = 0;
        for (int k = 0; k < nb; k++) v = v | (longint'(mb[addr + k]) << (8 * k));
        if (!uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
        rd = v[31:0];
      end
    end
    return {32'(icyc + (exc ? 1 : D_LAT + 1)), rd, exc, cause, exc ? addr : 32'd0};
  endfunction

  function automatic logic [EW-1:0] i_model(input logic [31:0] addr, input int icyc);
    bit mis, oor, exc;
    logic [31:0] rd;
    mis = (addr % 4) != 0;
    oor = (addr / 4) >= DEPTH;
    exc = mis || oor;
    rd = '0;
    if (!exc) for (int k = 0; k < 4; k++) rd = rd | (32'(mb[addr + k]) << (8 * k));
    return {32'(icyc + (exc ? 1 : I_LAT + 1)), rd, exc, mis ? 5'd0 : (oor ? 5'd1 : 5'd0),
            exc ? addr : 32'd0};
  endfunction

  // ------------------------------------------------------------ driver tasks
  // Called at a falling edge; request is presented until the accepting edge.
  task automatic d_issue(input bit we, input logic [1:0] size, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
    int k = 0;
    while (!d_ready && k < 64) begin @(negedge clk); k++; end
    if (!d_ready) begin note_fail("d_ready_timeout"); return; end
    d_req = 1'b1; d_we = we; d_size = size; d_unsigned = uns; d_addr = addr; d_wdata = wdata;
    d_q.push_back(d_model(we, size, uns, addr, wdata, cyc));
    @(negedge clk);
    d_req = 1'b0;
  endtask

  task automatic i_issue(input logic [31:0] addr, input bit push);
    int k = 0;
    while (!i_ready && k < 64) begin @(negedge clk); k++; end
    if (!i_ready) begin note_fail("i_ready_timeout"); return; end
    i_req = 1'b1; i_addr = addr;
    if (push) i_q.push_back(i_model(addr, cyc));
    @(negedge clk);
    i_req = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((i_q.size() != 0 || d_q.size() != 0 || !i_ready || !d_ready) && k < 300) begin
      @(negedge clk); k++;
    end
    if (i_q.size() != 0 || d_q.size() != 0) note_fail("drain_timeout");
  endtask

  task automatic d_random(input int n);
    bit we, uns;
    logic [1:0] size;
    logic [31:0] addr;
    int r;
    for (int t = 0; t < n; t++) begin
      we   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3));
      r    = $urandom_range(0, 15);
      if (r == 0)      addr = 32'h8000 + 32'($urandom_range(0, 15));
      else if (r == 1) addr = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else             addr = 32'h100 + 32'($urandom_range(0, 63));
      d_issue(we, size, uns, addr, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic i_random(input int n);
    logic [31:0] addr;
    int r;
    for (int t = 0; t < n; t++) begin
      r    = $urandom_range(0, 9);
      addr = 32'h200 + 32'(4 * $urandom_range(0, 15));
      if (r == 0)      addr = addr + 32'($urandom_range(1, 3));
      else if (r == 1) addr = 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 7));
      i_issue(addr, 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  // ------------------------------------------------------- scoreboard monitor
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (i_valid) begin
      if (i_q.size() == 0) note_fail("i_unexpected_valid");
      else begin
        e = i_q.pop_front();
        check("i_cycle", 32'(cyc), e[101:70]);
        check("i_rdata", i_rdata, e[69:38]);
        check("i_exc",   32'(i_exc), 32'(e[37]));
        check("i_cause", 32'(i_cause), 32'(e[36:32]));
        check("i_mtval", i_mtval, e[31:0]);
      end
    end
    if (d_valid) begin
      if (d_q.size() == 0) note_fail("d_unexpected_valid");
      else begin
        e = d_q.pop_front();
        check("d_cycle", 32'(cyc), e[101:70]);
        check("d_rdata", d_rdata, e[69:38]);
        check("d_exc",   32'(d_exc), 32'(e[37]));
        check("d_cause", 32'(d_cause), 32'(e[36:32]));
        check("d_mtval", d_mtval, e[31:0]);
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    repeat (3) @(negedge clk);
    check("rst_i_ready", 32'(i_ready), 32'd1);
    check("rst_d_ready", 32'(d_ready), 32'd1);
    check("rst_i_valid", 32'(i_valid), 32'd0);
    check("rst_d_valid", 32'(d_valid), 32'd0);
    check("rst_i_outs",  i_rdata | i_mtval | 32'(i_cause) | 32'(i_exc), 32'd0);
    check("rst_d_outs",  d_rdata | d_mtval | 32'(d_cause) | 32'(d_exc), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // word store/load, byte store, signed/unsigned sub-word loads
    d_issue(1, 2'b10, 0, 32'h4000, 32'h8765_4321);
    d_issue(0, 2'b10, 0, 32'h4000, 32'h0);
    d_issue(1, 2'b00, 0, 32'h4003, 32'h1234_56AB);
    d_issue(0, 2'b10, 0, 32'h4000, 32'h0);
    d_issue(0, 2'b00, 0, 32'h4003, 32'h0);
    d_issue(0, 2'b00, 1, 32'h4003, 32'h0);
    d_issue(0, 2'b01, 0, 32'h4002, 32'h0);
    d_issue(0, 2'b01, 1, 32'h4002, 32'h0);
    // misaligned and out-of-range traps
    d_issue(0, 2'b01, 0, 32'h4001, 32'h0);
    d_issue(1, 2'b10, 0, 32'h4002, 32'hDEAD_BEEF);
    d_issue(0, 2'b10, 0, 32'h4000, 32'h0);
    d_issue(0, 2'b10, 0, 32'(4 * DEPTH), 32'h0);
    d_issue(1, 2'b10, 0, 32'(4 * DEPTH), 32'h5555_5555);
    i_issue(32'h2, 1'b1);
    i_issue(32'(4 * DEPTH), 1'b1);
    wait_idle();
    // both ports trap on the same edge
    fork
      i_issue(32'(4 * DEPTH) + 32'h2, 1'b1);
      d_issue(1, 2'b01, 0, 32'(4 * DEPTH) + 32'h1, 32'h0);
    join
    wait_idle();

    // same-word collision: store write edge coincides with fetch read edge
    d_issue(1, 2'b10, 0, 32'h5000, 32'h1111_1111);
    wait_idle();
    fork
      i_issue(32'h5000, 1'b1);
      begin
        @(negedge clk);
        @(negedge clk);
        d_issue(1, 2'b10, 0, 32'h5000, 32'h2222_2222);
      end
    join
    wait_idle();
    i_issue(32'h5000, 1'b1);
    wait_idle();

    // reset during a fetch wait: no response, port idle at once
    i_issue(32'h5000, 1'b0);
    check("i_ready_in_wait", 32'(i_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("i_ready_after_rst", 32'(i_ready), 32'd1);
    check("i_valid_after_rst", 32'(i_valid), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    i_issue(32'h5000, 1'b1);
    wait_idle();

    // randomised traffic on disjoint regions for each port
    for (int w = 0; w < 16; w++) d_issue(1, 2'b10, 0, 32'h100 + 32'(4 * w), $urandom);
    for (int w = 0; w < 16; w++) d_issue(1, 2'b10, 0, 32'h200 + 32'(4 * w), $urandom);
    wait_idle();
    fork
      d_random(150);
      i_random(80);
    join
    wait_idle();
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    note_fail("global_timeout");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
